// File: rtl/instrumented_adder_seq.sv
// Measurement sequencer: clears an external toggle counter, enables the adder loop for a
// programmed window, waits for the counter to settle, then captures the count.
module instrumented_adder_seq #(
  parameter int CNT_W  = 32,
  parameter int SETTLE = 2
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] run_cycles,
  input  logic [CNT_W-1:0] count_in,
  output logic             counter_clr,
  output logic             adder_en,
  output logic             ready,
  output logic             done,
  output logic             aborted,
  output logic [CNT_W-1:0] result
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_RUN,
    ST_SETTLE,
    ST_CAPTURE
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] run_cnt_reg, run_cnt_next;
  logic [3:0]       settle_cnt_reg, settle_cnt_next;
  logic             done_reg, done_next;
  logic             aborted_reg, aborted_next;
  logic [CNT_W-1:0] result_reg, result_next;
  logic             counter_clr_reg, adder_en_reg, ready_reg;

  always_comb begin
    state_next      = state_reg;
    run_cnt_next    = run_cnt_reg;
    settle_cnt_next = settle_cnt_reg;
    done_next       = done_reg;
    aborted_next    = aborted_reg;
    result_next     = result_reg;

    case (state_reg)
      ST_IDLE: begin
        // abort is deliberately not looked at here, so start wins when both are high
        if (start) begin
          state_next   = ST_CLEAR;
          run_cnt_next = run_cycles;
          done_next    = 1'b0;
          aborted_next = 1'b0;
        end
      end
      ST_CLEAR: begin
        settle_cnt_next = '0;
        state_next      = (run_cnt_reg == '0) ? ST_SETTLE : ST_RUN;
      end
      ST_RUN: begin
        // The down-counter stops at zero on the last enable cycle; it never wraps.
        settle_cnt_next = '0;
        run_cnt_next    = run_cnt_reg - CNT_W'(1);
        if (run_cnt_reg == CNT_W'(1)) state_next = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (settle_cnt_reg == SETTLE_LAST) state_next = ST_CAPTURE;
        else settle_cnt_next = settle_cnt_reg + 4'd1;
      end
      ST_CAPTURE: begin
        state_next  = ST_IDLE;
        result_next = count_in;
        done_next   = 1'b1;
      end
      default: state_next = ST_IDLE;
    endcase

    if (abort && (state_reg == ST_CLEAR || state_reg == ST_RUN || state_reg == ST_SETTLE)) begin
      state_next   = ST_IDLE;
      aborted_next = 1'b1;
    end
  end

  // Strobes are registered from the next state so they line up with the state they describe.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_reg       <= ST_IDLE;
      run_cnt_reg     <= '0;
      settle_cnt_reg  <= '0;
      done_reg        <= 1'b0;
      aborted_reg     <= 1'b0;
      result_reg      <= '0;
      counter_clr_reg <= 1'b0;
      adder_en_reg    <= 1'b0;
      ready_reg       <= 1'b1;
    end else begin
      state_reg       <= state_next;
      run_cnt_reg     <= run_cnt_next;
      settle_cnt_reg  <= settle_cnt_next;
      done_reg        <= done_next;
      aborted_reg     <= aborted_next;
      result_reg      <= result_next;
      counter_clr_reg <= (state_next == ST_CLEAR);
      adder_en_reg    <= (state_next == ST_RUN);
      ready_reg       <= (state_next == ST_IDLE);
    end
  end

  assign counter_clr = counter_clr_reg;
  assign adder_en    = adder_en_reg;
  assign ready       = ready_reg;
  assign done        = done_reg;
  assign aborted     = aborted_reg;
  assign result      = result_reg;

endmodule

// File: tb/tb_instrumented_adder_seq.sv
// Directed bench for instrumented_adder_seq: a table of measurement runs plus
// hand-written reset-in-flight sequences. Counter width is reduced so all-ones is reachable.
module tb_instrumented_adder_seq;

  localparam int CNT_W  = 8;
  localparam int SETTLE = 2;

  logic             clk = 1'b0;
  logic             wb_rst_i;
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] run_cycles;
  logic [CNT_W-1:0] count_in;
  logic             counter_clr, adder_en, ready, done, aborted;
  logic [CNT_W-1:0] result;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  instrumented_adder_seq #(.CNT_W(CNT_W), .SETTLE(SETTLE)) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (wb_rst_i),
    .start      (start),
    .abort      (abort),
    .run_cycles (run_cycles),
    .count_in   (count_in),
    .counter_clr(counter_clr),
    .adder_en   (adder_en),
    .ready      (ready),
    .done       (done),
    .aborted    (aborted),
    .result     (result)
  );

  // External instrumentation counter: cleared by counter_clr, +1 per adder_en clock.
  logic [CNT_W-1:0] ext_cnt = 8'h5A;
  always @(posedge clk) begin
    if (counter_clr) ext_cnt <= '0;
    else if (adder_en) ext_cnt <= ext_cnt + 8'd1;
  end
  assign count_in = ext_cnt;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int len;        // run_cycles at start
    int abort_k;    // sample index to raise abort for one cycle (0 = with start, -1 none)
    int restart_k;  // sample index to re-pulse start with run_cycles=3 (-1 none)
    int exp_en;     // adder_en cycles
    int exp_clr;    // counter_clr cycles
    int exp_lat;    // edges from start edge (counted as 1) to done
    int exp_done;
    int exp_ab;
    int exp_res;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int en_n, clr_n, rdy_bad, k, quiet_bad;
    bit fin;

    // len, abort_k, restart_k, en, clr, lat, done, aborted, result
    vecs[0]  = '{10,  -1, -1,  10, 1,  15, 1, 0,  10};
    vecs[1]  = '{0,   -1, -1,   0, 1,   5, 1, 0,   0};
    vecs[2]  = '{1,   -1, -1,   1, 1,   6, 1, 0,   1};
    vecs[3]  = '{10,  -1,  5,  10, 1,  15, 1, 0,  10};
    vecs[4]  = '{5,    0, -1,   5, 1,  10, 1, 0,   5};
    vecs[5]  = '{7,   11, -1,   7, 1,  12, 1, 0,   7};
    vecs[6]  = '{100, 21, -1,  20, 1,   0, 0, 1,   7};
    vecs[7]  = '{4,    1, -1,   0, 1,   0, 0, 1,   7};
    vecs[8]  = '{3,    5, -1,   3, 1,   0, 0, 1,   7};
    vecs[9]  = '{255, -1, -1, 255, 1, 260, 1, 0, 255};
    vecs[10] = '{2,   -1, -1,   2, 1,   7, 1, 0,   2};

    wb_rst_i = 1'b1; start = 1'b0; abort = 1'b0; run_cycles = '0;
    tick(); tick();
    wb_rst_i = 1'b0;
    repeat (5) tick();
    check("reset_ready", int'(ready), 1);
    check("reset_done", int'(done), 0);
    check("reset_adder_en", int'(adder_en), 0);
    check("reset_result", int'(result), 0);
    check("reset_aborted", int'(aborted), 0);

    // abort in IDLE is ignored
    abort = 1'b1;
    repeat (3) tick();
    abort = 1'b0;
    check("idle_abort_ignored", int'(aborted), 0);
    check("idle_abort_ready", int'(ready), 1);

    foreach (vecs[v]) begin
      en_n = 0; clr_n = 0; rdy_bad = 0; k = 0; fin = 0;
      start = 1'b1; run_cycles = CNT_W'(vecs[v].len); abort = (vecs[v].abort_k == 0);
      while (!fin && k < 600) begin
        tick();
        k++;
        if (adder_en) en_n++;
        if (counter_clr) clr_n++;
        if (done || aborted) fin = 1;
        else if (ready) rdy_bad++;
        start      = (k == vecs[v].restart_k);
        run_cycles = (k == vecs[v].restart_k) ? 8'd3 : CNT_W'(vecs[v].len);
        abort      = (k == vecs[v].abort_k);
      end
      start = 1'b0; abort = 1'b0;
      check($sformatf("v%0d_finished", v), int'(fin), 1);
      check($sformatf("v%0d_en_cycles", v), en_n, vecs[v].exp_en);
      check($sformatf("v%0d_clr_cycles", v), clr_n, vecs[v].exp_clr);
      check($sformatf("v%0d_ready_low_in_run", v), rdy_bad, 0);
      check($sformatf("v%0d_done", v), int'(done), vecs[v].exp_done);
      check($sformatf("v%0d_aborted", v), int'(aborted), vecs[v].exp_ab);
      check($sformatf("v%0d_result", v), int'(result), vecs[v].exp_res);
      check($sformatf("v%0d_ready_end", v), int'(ready), 1);
      if (vecs[v].exp_done == 1) check($sformatf("v%0d_latency", v), k, vecs[v].exp_lat);
      quiet_bad = 0;
      repeat (20) begin
        tick();
        if (adder_en || counter_clr || !ready || (done != vecs[v].exp_done[0])) quiet_bad++;
      end
      check($sformatf("v%0d_idle_after", v), quiet_bad, 0);
    end

    // Reset during RUN: adder_en drops, no aborted, no capture.
    start = 1'b1; run_cycles = 8'd10;
    tick();
    start = 1'b0;
    repeat (4) tick();
    check("rst_run_en_before", int'(adder_en), 1);
    wb_rst_i = 1'b1;
    tick();
    wb_rst_i = 1'b0;
    check("rst_run_en", int'(adder_en), 0);
    check("rst_run_aborted", int'(aborted), 0);
    check("rst_run_done", int'(done), 0);
    check("rst_run_result", int'(result), 0);
    check("rst_run_ready", int'(ready), 1);

    // Reset during SETTLE with start also high: reset wins, nothing launches.
    start = 1'b1; run_cycles = 8'd10;
    tick();
    start = 1'b0;
    repeat (11) tick();   // sample 12: first SETTLE cycle
    check("rst_settle_en_low", int'(adder_en), 0);
    check("rst_settle_not_ready", int'(ready), 0);
    wb_rst_i = 1'b1; start = 1'b1; abort = 1'b1;
    tick();
    wb_rst_i = 1'b0; start = 1'b0; abort = 1'b0;
    check("rst_settle_ready", int'(ready), 1);
    check("rst_settle_done", int'(done), 0);
    check("rst_settle_aborted", int'(aborted), 0);
    check("rst_settle_clr", int'(counter_clr), 0);
    check("rst_settle_result", int'(result), 0);
    quiet_bad = 0;
    repeat (20) begin
      tick();
      if (adder_en || counter_clr || done || !ready) quiet_bad++;
    end
    check("rst_settle_no_run", quiet_bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/instrumented_adder_seq.md
INSTRUMENTED_ADDER_SEQ -- requirements
Module: instrumented_adder_seq

Interface
REQ-001 SHALL provide parameter CNT_W, default 32, width of run length and captured count.
REQ-002 SHALL provide parameter SETTLE, default 2, cycles between stopping the adder loop and capturing the count (range 1..15).
REQ-003 SHALL provide wb_clk_i  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL provide wb_rst_i  input  1  reset, synchronous, active-high.
REQ-005 SHALL provide start  input  1  request one measurement run; sampled only in IDLE.
REQ-006 SHALL provide abort  input  1  terminate the current run without capture.
REQ-007 SHALL provide run_cycles  input  CNT_W  length of the adder-enable window in clocks; latched at start.
REQ-008 SHALL provide count_in  input  CNT_W  live toggle count from the adder instrumentation counter.
REQ-009 SHALL provide counter_clr  output  1  clears the external instrumentation counter.
REQ-010 SHALL provide adder_en  output  1  enables the adder/oscillation loop.
REQ-011 SHALL provide ready  output  1  high when idle and able to accept start.
REQ-012 SHALL provide done  output  1  high when result is valid; held until the next accepted start.
REQ-013 SHALL provide aborted  output  1  high when the last run ended by abort; held until the next accepted start.
REQ-014 SHALL provide result  output  CNT_W  count_in captured at end of run.

Function
REQ-015 SHALL implement FSM states IDLE, CLEAR, RUN, SETTLE, CAPTURE.
REQ-016 IDLE: ready=1; on start=1 latch run_cycles, clear done and aborted, go to CLEAR next cycle.
REQ-017 start with run_cycles=0 SHALL be accepted; it goes IDLE->CLEAR->SETTLE with adder_en never asserted, and result captures the cleared count.
REQ-018 CLEAR: counter_clr=1 for exactly one cycle; next state RUN (or SETTLE if latched length is 0).
REQ-019 RUN: adder_en=1 for exactly the latched run_cycles consecutive clocks, timed by an internal down-counter; then SETTLE.
REQ-020 SETTLE: adder_en=0 for exactly SETTLE clocks; then CAPTURE.
REQ-021 CAPTURE: one cycle; result<=count_in, done<=1 registered at end of this cycle; next state IDLE.
REQ-022 Latency: from start sampled high to done high SHALL be run_cycles+SETTLE+3 clocks.
REQ-023 ready SHALL be 0 in every state except IDLE; start outside IDLE SHALL be ignored (not queued).
REQ-024 abort=1 in CLEAR, RUN or SETTLE SHALL force adder_en=0 next cycle, set aborted=1, leave done=0 and result unchanged, return to IDLE.
REQ-025 abort in IDLE or CAPTURE SHALL be ignored; CAPTURE completes normally.
REQ-026 start and abort both high in IDLE: start SHALL be accepted, abort ignored.
REQ-027 Changes to run_cycles after acceptance SHALL not affect the current run.
REQ-028 run_cycles = all-ones SHALL run 2^CNT_W-1 clocks with no wrap of the internal down-counter.
REQ-029 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-030 wb_rst_i=1 SHALL, on the next edge, force state IDLE, ready=1, done=0, aborted=0, adder_en=0, counter_clr=0, result=0, internal counters=0.
REQ-031 Reset asserted mid-run SHALL drop adder_en on the next edge and discard the run without setting aborted.
REQ-032 Reset SHALL take priority over start and abort in the same cycle.

Verification
REQ-033 Reset then idle 5 clocks -> ready=1, done=0, adder_en=0, result=0.
REQ-034 run_cycles=10, start pulse, count_in ramps +1 per adder_en cycle -> counter_clr 1 cycle, adder_en exactly 10 cycles, done at start+15 clocks, result=10, ready back to 1.
REQ-035 run_cycles=0, start -> adder_en never high, done after 3+SETTLE clocks, result = count_in value after clear (0).
REQ-036 run_cycles=100, abort at 20th adder_en cycle -> adder_en low next clock, aborted=1, done=0, result holds previous value.
REQ-037 start re-pulsed during RUN and run_cycles changed to 3 mid-run -> ignored; run still 10 cycles, single done.
REQ-038 wb_rst_i asserted during SETTLE with start also high -> IDLE, all outputs at reset values, no capture.
